// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory write path: default widths,
// the queue entry layout and the word-granular address compare.
package dmem_pkg;

    localparam int DMEM_AW = 32;
    localparam int DMEM_DW = 32;
    localparam int MAX_AW  = 64;

    typedef struct packed {
        logic [DMEM_AW-1:0] addr;
        logic [DMEM_DW-1:0] data;
    } dmemEntry_t;

    // Callers zero-extend to MAX_AW; bits [1:0] are the byte offset and are ignored.
    function automatic logic wordMatch(input logic [MAX_AW-1:0] a, input logic [MAX_AW-1:0] b);
        return a[MAX_AW-1:2] == b[MAX_AW-1:2];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: pointer register plus a combinational one-hot grant
// searching upward from the pointer and wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                                         CLK,
    input  logic                                         Reset,
    input  logic [NUM_REQ-1:0]                           ReqValid,
    input  logic                                         Enable,
    output logic [NUM_REQ-1:0]                           Grant,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] GrantIdx,
    output logic                                         GrantValid
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [GW-1:0] ptr;

    function automatic int wrapIdx(input int base, input int k);
        return (base + k) % NUM_REQ;
    endfunction

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        Grant      = '0;
        GrantIdx   = '0;
        GrantValid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!GrantValid && Enable && ReqValid[wrapIdx(int'(ptr), k)]) begin
                GrantValid                       = 1'b1;
                Grant[wrapIdx(int'(ptr), k)]     = 1'b1;
                GrantIdx                         = GW'(wrapIdx(int'(ptr), k));
            end
        end
    end

    // NOTE: state registers use non-blocking assignments; combinational blocks use blocking.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            ptr <= '0;
        end else if (GrantValid) begin
            ptr <= (GrantIdx == GW'(NUM_REQ - 1)) ? '0 : GrantIdx + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_write_arbiter.sv
// Shares the data_mem write port between NUM_REQ store requesters through a
// round-robin grant and an in-order write queue, and flags conflicting loads.
module dmem_write_arbiter
    import dmem_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int AW      = DMEM_AW,
    parameter int DW      = DMEM_DW,
    parameter int DEPTH   = 4
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic [NUM_REQ-1:0]       ReqValid,
    input  logic [NUM_REQ*AW-1:0]    ReqAddr,
    input  logic [NUM_REQ*DW-1:0]    ReqData,
    output logic [NUM_REQ-1:0]       ReqReady,
    input  logic                     Hold,
    input  logic [AW-1:0]            LoadRA,
    output logic                     LoadConflict,
    output logic                     DataMem_WE,
    output logic [AW-1:0]            DataMem_WA,
    output logic [DW-1:0]            DataMem_WD,
    output logic                     Empty,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } qEntry_t;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    qEntry_t       queue [DEPTH];

    logic          full;
    logic          push;
    logic          pop;
    logic [GW-1:0] grantIdx;
    logic          grantValid;
    qEntry_t       incoming;
    logic          pendingMatch;
    logic [PW-1:0] offs;

    assign full  = (count == (PW+1)'(DEPTH));
    assign Empty = (count == '0);
    assign Count = count;

    // Reset gates the grant so ReqReady drops the instant Reset asserts.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) uArb (
        .CLK        (CLK),
        .Reset      (Reset),
        .ReqValid   (ReqValid),
        .Enable     (!full && Reset),
        .Grant      (ReqReady),
        .GrantIdx   (grantIdx),
        .GrantValid (grantValid)
    );

    assign incoming.addr = ReqAddr[grantIdx*AW +: AW];
    assign incoming.data = ReqData[grantIdx*DW +: DW];

    assign push       = grantValid;
    assign DataMem_WE = !Empty && !Hold;
    assign pop        = DataMem_WE;
    assign DataMem_WA = Empty ? '0 : queue[head].addr;
    assign DataMem_WD = Empty ? '0 : queue[head].data;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: queue storage is deliberately not reset; count decides which slots are meaningful.
    always_ff @(posedge CLK) begin
        if (push) queue[tail] <= incoming;
    end

    // The head entry stays live through its pop cycle, so a load racing the drain still stalls.
    always_comb begin
        pendingMatch = 1'b0;
        offs         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - head;
            if (((PW+1)'(offs) < count) &&
                wordMatch(MAX_AW'(queue[i].addr), MAX_AW'(LoadRA))) begin
                pendingMatch = 1'b1;
            end
        end
    end

    assign LoadConflict = pendingMatch ||
                          (grantValid && wordMatch(MAX_AW'(incoming.addr), MAX_AW'(LoadRA)));

endmodule

// File: tb/tb_dmem_write_arbiter.sv
// Directed bench for dmem_write_arbiter with a FIFO scoreboard and hand-placed checks.
module tb_dmem_write_arbiter;

    logic        CLK;
    logic        Reset;
    logic [1:0]  ReqValid;
    logic [63:0] ReqAddr;
    logic [63:0] ReqData;
    logic [1:0]  ReqReady;
    logic        Hold;
    logic [31:0] LoadRA;
    logic        LoadConflict;
    logic        DataMem_WE;
    logic [31:0] DataMem_WA;
    logic [31:0] DataMem_WD;
    logic        Empty;
    logic [2:0]  Count;

    dmem_write_arbiter #(.NUM_REQ(2), .AW(32), .DW(32), .DEPTH(4)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .ReqValid     (ReqValid),
        .ReqAddr      (ReqAddr),
        .ReqData      (ReqData),
        .ReqReady     (ReqReady),
        .Hold         (Hold),
        .LoadRA       (LoadRA),
        .LoadConflict (LoadConflict),
        .DataMem_WE   (DataMem_WE),
        .DataMem_WA   (DataMem_WA),
        .DataMem_WD   (DataMem_WD),
        .Empty        (Empty),
        .Count        (Count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    int   expPtr;
    int   numChecks;
    int   numErrors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        numChecks++;
        if (obs !== exp) begin
            numErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check combinational outputs against the scoreboard, advance.
    task automatic cycle(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] d0,
                         input logic [31:0] a1, input logic [31:0] d1,
                         input logic hold, input logic [31:0] lra, input string tag);
        logic [1:0]  expReady;
        logic        expWe;
        logic        expConf;
        logic [31:0] ga;
        logic [31:0] gd;
        int          g;
        int          idx;
        ReqValid = v;
        ReqAddr  = {a1, a0};
        ReqData  = {d1, d0};
        Hold     = hold;
        LoadRA   = lra;
        #1;
        g = -1;
        if (mq.size() < 4) begin
            for (int k = 0; k < 2; k++) begin
                idx = (expPtr + k) % 2;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        expReady = 2'b00;
        ga = (g == 1) ? a1 : a0;
        gd = (g == 1) ? d1 : d0;
        if (g >= 0) expReady[g] = 1'b1;
        expWe   = (mq.size() > 0) && !hold;
        expConf = (g >= 0) && (ga[31:2] == lra[31:2]);
        foreach (mq[i]) if (mq[i].a[31:2] == lra[31:2]) expConf = 1'b1;
        check({tag, ".ready"}, ReqReady, expReady);
        check({tag, ".we"}, DataMem_WE, expWe);
        check({tag, ".wa"}, DataMem_WA, (mq.size() > 0) ? mq[0].a : 32'h0);
        check({tag, ".wd"}, DataMem_WD, (mq.size() > 0) ? mq[0].d : 32'h0);
        check({tag, ".count"}, Count, mq.size());
        check({tag, ".empty"}, Empty, mq.size() == 0);
        check({tag, ".conflict"}, LoadConflict, expConf);
        @(posedge CLK);
        if (expWe) void'(mq.pop_front());
        if (g >= 0) begin
            mq.push_back('{a: ga, d: gd});
            expPtr = (g + 1) % 2;
        end
        #1;
    endtask

    initial begin
        numChecks = 0;
        numErrors = 0;
        expPtr    = 0;
        Reset     = 1'b0;
        ReqValid  = 2'b11;
        ReqAddr   = {32'h14, 32'h10};
        ReqData   = '0;
        Hold      = 1'b0;
        LoadRA    = 32'h10;
        #3;
        check("rst.ready", ReqReady, 2'b00);
        check("rst.we", DataMem_WE, 1'b0);
        check("rst.wa", DataMem_WA, 32'h0);
        check("rst.wd", DataMem_WD, 32'h0);
        check("rst.conflict", LoadConflict, 1'b0);
        check("rst.empty", Empty, 1'b1);
        check("rst.count", Count, 3'd0);
        @(posedge CLK);
        #1;
        Reset    = 1'b1;
        ReqValid = 2'b00;

        // Single store, earliest write on the following cycle.
        cycle(2'b01, 32'h10, 32'hAAAA5555, 32'h0, 32'h0, 1'b0, 32'h10, "t1.push");
        ReqValid = 2'b00;
        #1;
        check("t1.we", DataMem_WE, 1'b1);
        check("t1.wa", DataMem_WA, 32'h10);
        check("t1.wd", DataMem_WD, 32'hAAAA5555);
        cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, "t1.drain");
        check("t1.count", Count, 3'd0);

        // Both requesters contend continuously: grants alternate.
        for (int i = 0; i < 4; i++)
            cycle(2'b11, 32'h100 + i*8, 32'h1000 + i, 32'h200 + i*8, 32'h2000 + i,
                  1'b0, 32'h0, "t2.rr");
        cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, "t2.drain");

        // Hold fills the queue; fifth offer is refused.
        for (int i = 0; i < 5; i++)
            cycle(2'b01, 32'h300 + i*4, 32'h3000 + i, 32'h0, 32'h0, 1'b1, 32'h0, "t3.fill");
        check("t3.count", Count, 3'd4);
        for (int i = 0; i < 4; i++)
            cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, "t3.drain");
        ReqValid = 2'b01;
        #1;
        check("t3.reassert", ReqReady, 2'b01);
        cycle(2'b01, 32'h380, 32'h3800, 32'h0, 32'h0, 1'b0, 32'h0, "t3.push");
        cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, "t3.last");

        // Word-granular load conflict against a held store.
        cycle(2'b01, 32'h20, 32'hBEEF, 32'h0, 32'h0, 1'b1, 32'h22, "t4.push");
        cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h22, "t4.held");
        LoadRA = 32'h22;
        #1;
        check("t4.match", LoadConflict, 1'b1);
        LoadRA = 32'h24;
        #1;
        check("t4.nomatch", LoadConflict, 1'b0);
        cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h22, "t4.drain");
        LoadRA = 32'h22;
        #1;
        check("t4.after", LoadConflict, 1'b0);

        // Push and pop together at depth 3, then run past the pointer wrap.
        for (int i = 0; i < 3; i++)
            cycle(2'b10, 32'h0, 32'h0, 32'h400 + i*4, 32'h4000 + i, 1'b1, 32'h0, "t5.fill");
        cycle(2'b11, 32'h500, 32'h5000, 32'h504, 32'h5004, 1'b0, 32'h0, "t5.pushpop");
        check("t5.count", Count, 3'd3);
        for (int i = 0; i < 5; i++)
            cycle(2'b11, 32'h600 + i*8, 32'h6000 + i, 32'h700 + i*8, 32'h7000 + i,
                  1'b0, 32'h0, "t5.wrap");
        for (int i = 0; i < 3; i++)
            cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, "t5.drain");

        // Asynchronous reset in the middle of a drain.
        for (int i = 0; i < 3; i++)
            cycle(2'b01, 32'h800 + i*4, 32'h8000 + i, 32'h0, 32'h0, 1'b1, 32'h0, "t6.fill");
        ReqValid = 2'b00;
        Hold     = 1'b0;
        #1;
        check("t6.we_pre", DataMem_WE, 1'b1);
        Reset = 1'b0;
        #1;
        check("t6.we", DataMem_WE, 1'b0);
        check("t6.empty", Empty, 1'b1);
        check("t6.count", Count, 3'd0);
        Reset = 1'b1;
        mq.delete();
        expPtr = 0;
        @(posedge CLK);
        #1;
        ReqValid = 2'b11;
        #1;
        check("t6.grant0", ReqReady, 2'b01);
        cycle(2'b11, 32'h900, 32'h9000, 32'h904, 32'h9004, 1'b0, 32'h0, "t6.push");
        cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, "t6.drain");

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule

// File: doc/dmem_write_arbiter.md
Name: dmem_write_arbiter

Overview:
- Shares the single data_mem write port (WE/WA/WD) between NUM_REQ store requesters, e.g. the superscalar commit lanes.
- Selects at most one store per cycle using a round-robin grant.
- Buffers accepted stores in an in-order write queue and drains one entry per cycle to data_mem.
- Flags loads whose word address matches a pending store, so the core can stall the load until the store lands.

Parameters:
- NUM_REQ, 2, number of store requesters.
- AW, 32, address width.
- DW, 32, data width.
- DEPTH, 4, write-queue entries; must be a power of 2 and at least 2.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- ReqValid  input  NUM_REQ  per-requester store valid.
- ReqAddr  input  NUM_REQ*AW  per-requester byte address; requester i occupies slice i.
- ReqData  input  NUM_REQ*DW  per-requester store data; requester i occupies slice i.
- ReqReady  output  NUM_REQ  one-hot grant; the store is accepted when ReqValid[i] and ReqReady[i] are both high.
- Hold  input  1  stalls draining; queue acceptance continues.
- LoadRA  input  AW  address of a load being issued this cycle.
- LoadConflict  output  1  LoadRA word-matches a pending or incoming store.
- DataMem_WE  output  1  write enable to data_mem.
- DataMem_WA  output  AW  write address to data_mem.
- DataMem_WD  output  DW  write data to data_mem.
- Empty  output  1  write queue is empty.
- Count  output  clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (asynchronous, Reset=0):
  - Queue is cleared; head, tail and Count go to 0; Empty=1.
  - Round-robin pointer goes to 0.
  - Outputs immediately become ReqReady=0, DataMem_WE=0, DataMem_WA=0, DataMem_WD=0, LoadConflict=0.
  - Reset mid-operation discards queued stores silently.
- Arbitration (combinational):
  - When the queue is not full, grant the first requester with ReqValid=1, searching from pointer index upward and wrapping modulo NUM_REQ.
  - ReqReady is high only for the granted requester.
  - Full queue: ReqReady is all zeros, even if a pop occurs in the same cycle (no pass-through).
  - No ReqValid: ReqReady=0.
  - ReqReady never depends on the requester's own ReqValid beyond selection.
- Pointer update:
  - On an accepted grant g, pointer <= (g+1) mod NUM_REQ.
  - With no grant, the pointer holds.
- Enqueue: the accepted {addr, data} is written at tail on the rising edge, and tail increments modulo DEPTH.
- Drain (combinational from head):
  - DataMem_WE = !Empty && !Hold.
  - DataMem_WA and DataMem_WD = head entry; they are 0 when Empty.
  - When DataMem_WE=1, head increments at the edge, so data_mem and the queue update on the same edge.
- Latency: a store accepted in cycle N drives DataMem_WE in cycle N+1 at the earliest, given an empty queue and Hold=0.
- Ordering: strict FIFO across all requesters; stores are never reordered or merged.
- Simultaneous push and pop: Count is unchanged, and both pointers advance.
- Count and Empty:
  - Count updates as +1 on push only, -1 on pop only.
  - Empty = (Count == 0).
  - Full = (Count == DEPTH).
- Wrap-around: head and tail are clog2(DEPTH) bits and wrap naturally.
- LoadConflict (combinational) is 1 if either condition holds:
  - any valid queue entry has addr[AW-1:2] == LoadRA[AW-1:2];
  - the store being granted this cycle matches on the same bits.
- The entry popped in the current cycle still counts as a conflict (conservative).
- Addresses are compared at word granularity only; byte offsets are ignored.

Decomposition:
- Shared package dmem_pkg holds:
  - the AW and DW defaults;
  - the word-compare macro/function (addr[AW-1:2]);
  - a struct/typedef for a queue entry {addr, data}.
- One sub-module, rr_arbiter (NUM_REQ), provides the pointer register plus the combinational grant.
- The queue and conflict compare stay in dmem_write_arbiter.

Test Plan:
- Reset release, then requester 0 stores addr 0x10, data 0xAAAA5555 in cycle 1 -> ReqReady=01; in cycle 2 DataMem_WE=1, WA=0x10, WD=0xAAAA5555; Count=0 afterwards.
- Both requesters valid continuously with distinct stores, Hold=0 -> grants alternate 01, 10, 01, 10; data_mem writes appear in grant order, one per cycle.
- Hold=1 while 5 stores are offered -> 4 accepted; Count=4; ReqReady=00 in cycle 5; release Hold -> 4 consecutive WE cycles, then ReqReady reasserts.
- Queue holds store to 0x20, LoadRA=0x22 -> LoadConflict=1; LoadRA=0x24 -> 0; after the 0x20 entry drains, 0x22 -> 0.
- Fill to 3 entries, then push and pop in the same cycle -> Count stays 3; continue pushing past the wrap -> data_mem sequence matches enqueue order.
- Assert Reset mid-drain with Count=3 -> DataMem_WE=0 the same cycle (asynchronous); Empty=1; next grant goes to requester 0.
